timer_phase_sequencer: RTL and testbench

//  Controller for the 1 Hz countdown timer. Steps it through NUM_PHASES timed phases,
//  e.g. traffic-light green/yellow/red, with a programmable duration per phase.

---
 rtl/timer_phase_sequencer.sv | 83 ++++++++
 tb/tb_timer_phase_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/timer_phase_sequencer.sv
// timer_phase_sequencer: steps a 1 Hz countdown timer through NUM_PHASES programmable phases.
// Define SEQ_AUTO_LOOP_EN to repeat the sequence forever instead of stopping after the last phase.
module timer_phase_sequencer #(
  parameter int NUM_PHASES = 3,
  parameter int CW = 8,
  parameter int PW = 2
) (
  input  logic                     clk_1hz,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     pause,
  input  logic                     abort,
  input  logic [NUM_PHASES*CW-1:0] phase_dur,
  input  logic [CW-1:0]            timer_count,
  input  logic                     timer_time_up,
  output logic                     timer_load,
  output logic [CW-1:0]            timer_preset,
  output logic [PW-1:0]            phase_idx,
  output logic                     phase_start,
  output logic                     busy,
  output logic                     seq_done
);
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, PAUSE} state_t;
`ifdef SEQ_AUTO_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  localparam logic [PW-1:0] LAST = PW'(NUM_PHASES - 1);
  state_t state;
  logic [CW-1:0] hold_cnt;
  logic last, run_up, to_load, to_idle;
  logic [PW-1:0] load_idx;
  always_comb begin
    last = phase_idx == LAST;
    run_up = state == RUN && !abort && timer_time_up;
    to_load = (state == IDLE && start) || (run_up && (!last || LOOP));
    to_idle = ((state == RUN || state == PAUSE) && abort) || (run_up && last && !LOOP);
    load_idx = (run_up && !last) ? phase_idx + PW'(1) : '0;
  end
  // Outputs are set on the edge entering a state, so the preset is ready while LOAD is visible.
  always_ff @(posedge clk_1hz or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      hold_cnt <= '0;
      timer_load <= 1'b0;
      timer_preset <= '0;
      phase_idx <= '0;
      phase_start <= 1'b0;
      busy <= 1'b0;
      seq_done <= 1'b0;
    end else begin
      phase_start <= to_load;
      seq_done <= run_up && last;
      if (to_load) begin
        state <= LOAD;
        phase_idx <= load_idx;
        timer_load <= 1'b1;
        timer_preset <= phase_dur[load_idx*CW +: CW];
        busy <= 1'b1;
      end else if (to_idle) begin
        state <= IDLE;
        phase_idx <= '0;
        timer_load <= 1'b0;
        busy <= 1'b0;
      end else if (state == LOAD) begin
        state <= SETTLE;
        timer_load <= 1'b0;
      end else if (state == SETTLE) begin
        state <= RUN;
      end else if (state == RUN && pause) begin
        state <= PAUSE;
        hold_cnt <= timer_count;
        timer_load <= 1'b1;
        timer_preset <= timer_count;
      end else if (state == PAUSE) begin
        state <= pause ? PAUSE : SETTLE;
        timer_load <= pause;
        timer_preset <= hold_cnt;
      end
    end
  end
endmodule

// File: tb/tb_timer_phase_sequencer.sv
// tb_timer_phase_sequencer: random and directed checks against a countdown-timer model and a phase-rule model.
module tb_timer_phase_sequencer;
  localparam int NP = 3;
  localparam int CW = 8;
`ifdef SEQ_AUTO_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  logic clk = 0, reset_n = 0, start = 0, pause = 0, abort = 0;
  logic [NP*CW-1:0] phase_dur = '0;
  logic [CW-1:0] tcount, timer_preset;
  logic tup, timer_load, phase_start, busy, seq_done;
  logic [1:0] phase_idx;
  int total = 0, bad = 0, cyc = 0;
  always #5 clk = ~clk;
  timer_phase_sequencer dut (
    .clk_1hz(clk), .reset_n(reset_n), .start(start), .pause(pause), .abort(abort),
    .phase_dur(phase_dur), .timer_count(tcount), .timer_time_up(tup),
    .timer_load(timer_load), .timer_preset(timer_preset), .phase_idx(phase_idx),
    .phase_start(phase_start), .busy(busy), .seq_done(seq_done)
  );
  // Countdown timer the sequencer drives: saturates at 0, time_up lags the zero count by one cycle.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tcount <= '0;
      tup <= 1'b0;
    end else begin
      tup <= tcount == 0;
      tcount <= timer_load ? timer_preset : (tcount != 0 ? tcount - 1'b1 : tcount);
    end
  // Reference: mode 0 idle, 1 load, 2 settle, 3 run, 4 pause.
  int m_mode, m_idx, m_pre;
  bit m_load, m_ps, m_busy, m_done;
  function automatic int dur_of(int k);
    return int'(phase_dur[k*CW +: CW]);
  endfunction
  task automatic m_enter(int k);
    m_mode <= 1; m_idx <= k; m_load <= 1; m_pre <= dur_of(k); m_ps <= 1; m_busy <= 1;
  endtask
  task automatic m_quit();
    m_mode <= 0; m_idx <= 0; m_load <= 0; m_busy <= 0;
  endtask
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      m_mode <= 0; m_idx <= 0; m_pre <= 0; m_load <= 0; m_ps <= 0; m_busy <= 0; m_done <= 0;
    end else begin
      m_ps <= 0;
      m_done <= 0;
      if (m_mode == 0 && start) m_enter(0);
      else if (m_mode == 1) begin m_mode <= 2; m_load <= 0; end
      else if (m_mode == 2) m_mode <= 3;
      else if (m_mode == 3) begin
        if (abort) m_quit();
        else if (tup && m_idx == NP - 1) begin
          m_done <= 1;
          if (LOOP) m_enter(0); else m_quit();
        end else if (tup) m_enter(m_idx + 1);
        else if (pause) begin m_mode <= 4; m_load <= 1; m_pre <= int'(tcount); end
      end else if (m_mode == 4) begin
        if (abort) m_quit();
        else if (!pause) begin m_mode <= 2; m_load <= 0; end
      end
    end
  task automatic check(string tag, int obs, int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s obs=%0d exp=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (reset_n) begin
      check("load", int'(timer_load), int'(m_load));
      check("preset", int'(timer_preset), m_pre);
      check("idx", int'(phase_idx), m_idx);
      check("phase_start", int'(phase_start), int'(m_ps));
      check("busy", int'(busy), int'(m_busy));
      check("seq_done", int'(seq_done), int'(m_done));
    end
  task automatic check_zero(string tag);
    check({tag, "_load"}, int'(timer_load), 0);
    check({tag, "_preset"}, int'(timer_preset), 0);
    check({tag, "_idx"}, int'(phase_idx), 0);
    check({tag, "_ps"}, int'(phase_start), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(seq_done), 0);
  endtask
  task automatic do_reset();
    start = 0; pause = 0; abort = 0;
    @(negedge clk); reset_n = 0;
    @(negedge clk); reset_n = 1;
  endtask
  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_for(input int which, output int c);
    c = -1;
    for (int i = 0; i < 300; i++) begin
      if ((which == 0 && phase_start) || (which == 1 && seq_done)) begin c = cyc; break; end
      @(negedge clk);
    end
    if (c < 0) check(which == 0 ? "timeout_phase_start" : "timeout_seq_done", 0, 1);
    @(negedge clk);
  endtask
  int c0, c1, c2, c3, pl, found;
  initial begin
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset_n = 1;
    phase_dur = {8'd4, 8'd2, 8'd5};
    @(negedge clk);
    pulse_start();
    wait_for(0, c0); wait_for(0, c1); wait_for(0, c2); wait_for(1, c3);
    check("s2_gap0", c1 - c0, 8);
    check("s2_gap1", c2 - c1, 5);
    check("s2_done_gap", c3 - c2, 7);
    if (!LOOP) check("s2_idle_busy", int'(busy), 0);
    do_reset();
    pulse_start();
    wait_for(0, c0);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (m_mode == 3 && tcount == 3) found = 1; else @(negedge clk);
    end
    check("s3_reach_count3", found, 1);
    pause = 1;
    repeat (5) @(negedge clk);
    check("s3_pause_load", int'(timer_load), 1);
    check("s3_pause_preset", int'(timer_preset), 3);
    repeat (5) @(negedge clk);
    pause = 0;
    wait_for(0, c1);
    check("s3_gap_in_range", int'((c1 - c0) == 18 || (c1 - c0) == 19), 1);
    do_reset();
    phase_dur = '0;
    pulse_start();
    wait_for(0, c0);
    wait_for(1, c3);
    check("s5_zero_dur_done", c3 - c0, 9);
    do_reset();
    pl = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = $urandom_range(0, 7) == 0;
      abort = $urandom_range(0, 79) == 0;
      if (pl > 0) pl--;
      else if ($urandom_range(0, 30) == 0) pl = $urandom_range(1, 6);
      pause = pl > 0;
      if ($urandom_range(0, 40) == 0)
        phase_dur = {8'($urandom_range(0, 6)), 8'($urandom_range(0, 6)), 8'($urandom_range(0, 6))};
    end
    start = 0; pause = 0; abort = 0;
    do_reset();
    phase_dur = {8'd4, 8'd2, 8'd5};
    pulse_start();
    repeat (4) @(negedge clk);
    check("s1_busy_before", int'(busy), 1);
    #2 reset_n = 0;
    #1 check_zero("s1_async");
    @(negedge clk); reset_n = 1;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
